unidade_controle_rodadas: RTL and testbench

UNIDADE_CONTROLE_RODADAS -- requirements
Module: unidade_controle_rodadas

---
 rtl/unidade_controle_rodadas.sv | 167 ++++++++++++++++
 tb/tb_unidade_controle_rodadas.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_rodadas.sv
// Round-control FSM for a memory-sequence game.
// Optional play timer enabled by UNIDADE_CONTROLE_TIMEOUT_EN.
module unidade_controle_rodadas #(
  parameter int ADDR_W     = 4,
  parameter int LAST_ROUND = 15,
  parameter int TIMEOUT    = 5000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              tem_jogada,
  input  logic              jogadaIgualMemoria,
  output logic              zeraR,
  output logic              registraR,
  output logic [ADDR_W-1:0] endereco,
  output logic [ADDR_W-1:0] rodada,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  if (TIMEOUT < 1 || LAST_ROUND < 0 ||
      LAST_ROUND >= 2**ADDR_W) begin : g_bad_param
    $error("unidade_controle_rodadas: illegal parameters");
  end

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMO        = 4'h6,
    ULTIMA_RODADA  = 4'h7,
    PROXIMA_RODADA = 4'h8,
    FINAL_ACERTO   = 4'hA,
    FINAL_TIMEOUT  = 4'hD,
    FINAL_ERRO     = 4'hE
  } estado_t;

  estado_t estado, prox;

  logic zera_end, inc_end;
  logic zera_rod, inc_rod;
  logic expirou;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= prox;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      endereco <= '0;
      rodada   <= '0;
    end else begin
      if (zera_end)     endereco <= '0;
      else if (inc_end) endereco <= endereco + ADDR_W'(1);
      if (zera_rod)     rodada <= '0;
      else if (inc_rod) rodada <= rodada + ADDR_W'(1);
    end
  end

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] timer;

  assign expirou = (timer == TW'(TIMEOUT - 1));

  // Restarts from zero on every entry into espera_jogada.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      timer <= '0;
    else if (estado == ESPERA_JOGADA &&
             prox == ESPERA_JOGADA)
      timer <= timer + TW'(1);
    else
      timer <= '0;
  end
`else
  assign expirou = 1'b0;
`endif

  always_comb begin
    prox      = estado;
    zera_end  = 1'b0;
    inc_end   = 1'b0;
    zera_rod  = 1'b0;
    inc_rod   = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    pronto    = 1'b0;
    db_estado = estado;
    case (estado)
      INICIAL: begin
        zeraR = 1'b1;
        if (iniciar) prox = PREPARACAO;
      end
      PREPARACAO: begin
        zeraR    = 1'b1;
        zera_end = 1'b1;
        zera_rod = 1'b1;
        prox     = ESPERA_JOGADA;
      end
      INICIA_RODADA: begin
        zera_end = 1'b1;
        prox     = ESPERA_JOGADA;
      end
      ESPERA_JOGADA: begin
        if (tem_jogada)   prox = REGISTRA;
        else if (expirou) prox = FINAL_TIMEOUT;
      end
      REGISTRA: begin
        registraR = 1'b1;
        prox      = COMPARACAO;
      end
      COMPARACAO: begin
        if (!jogadaIgualMemoria)   prox = FINAL_ERRO;
        else if (endereco == rodada) prox = ULTIMA_RODADA;
        else                       prox = PROXIMO;
      end
      PROXIMO: begin
        inc_end = 1'b1;
        prox    = ESPERA_JOGADA;
      end
      ULTIMA_RODADA: begin
        if (rodada == ADDR_W'(LAST_ROUND))
          prox = FINAL_ACERTO;
        else
          prox = PROXIMA_RODADA;
      end
      PROXIMA_RODADA: begin
        inc_rod = 1'b1;
        prox    = INICIA_RODADA;
      end
      FINAL_ACERTO: begin
        acertou = 1'b1;
        pronto  = 1'b1;
        if (iniciar) prox = PREPARACAO;
      end
      FINAL_ERRO: begin
        errou  = 1'b1;
        pronto = 1'b1;
        if (iniciar) prox = PREPARACAO;
      end
      FINAL_TIMEOUT: begin
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
        timeout = 1'b1;
`endif
        pronto = 1'b1;
        if (iniciar) prox = PREPARACAO;
      end
      default: begin
        db_estado = 4'hF;
        prox      = INICIAL;
      end
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Bench for unidade_controle_rodadas: vector table plus scoreboard.
// Timer cases follow UNIDADE_CONTROLE_TIMEOUT_EN.
module tb_unidade_controle_rodadas;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       tem_jogada = 1'b0;
  logic       jogada = 1'b0;
  logic       zeraR, registraR;
  logic [3:0] endereco, rodada;
  logic       acertou, errou, timeout, pronto;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       m;
    logic [3:0] db;
    logic [3:0] en;
    logic [3:0] rd;
  } vec_t;

  typedef struct {
    logic [3:0] db;
    logic [3:0] en;
    logic [3:0] rd;
  } exp_t;

  vec_t vec [15];
  exp_t sb [$];

  unidade_controle_rodadas #(
    .ADDR_W(4),
    .LAST_ROUND(3),
    .TIMEOUT(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .tem_jogada(tem_jogada),
    .jogadaIgualMemoria(jogada),
    .zeraR(zeraR),
    .registraR(registraR),
    .endereco(endereco),
    .rodada(rodada),
    .acertou(acertou),
    .errou(errou),
    .timeout(timeout),
    .pronto(pronto),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic wait_db(input logic [3:0] target,
                         input string name);
    int n = 0;
    while (db_estado !== target && n < 20) begin
      tick();
      n++;
    end
    chk(name, db_estado, target);
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    tick();
    chk("prep_db", db_estado, 4'h1);
    chk("prep_zeraR", 4'(zeraR), 4'd1);
    iniciar = 1'b0;
    wait_db(4'h3, "enter_espera");
  endtask

  task automatic drive(input vec_t v);
    wait_db(4'h3, "espera");
    tem_jogada = 1'b1;
    jogada     = v.m;
    sb.push_back('{v.db, v.en, v.rd});
    tick();
    chk("registraR", 4'(registraR), 4'd1);
    tem_jogada = 1'b0;
    tick();
    chk("comparacao", db_estado, 4'h5);
  endtask

  task automatic resolve();
    exp_t e;
    tick();
    e = sb.pop_front();
    chk("cmp_db", db_estado, e.db);
    chk("cmp_end", endereco, e.en);
    chk("cmp_rod", rodada, e.rd);
  endtask

  task automatic play(input vec_t v);
    drive(v);
    resolve();
  endtask

  initial begin
    vec[0]  = '{1'b1, 4'h7, 4'd0, 4'd0};
    vec[1]  = '{1'b1, 4'h6, 4'd0, 4'd1};
    vec[2]  = '{1'b1, 4'h7, 4'd1, 4'd1};
    vec[3]  = '{1'b1, 4'h6, 4'd0, 4'd2};
    vec[4]  = '{1'b1, 4'h6, 4'd1, 4'd2};
    vec[5]  = '{1'b1, 4'h7, 4'd2, 4'd2};
    vec[6]  = '{1'b1, 4'h6, 4'd0, 4'd3};
    vec[7]  = '{1'b1, 4'h6, 4'd1, 4'd3};
    vec[8]  = '{1'b1, 4'h6, 4'd2, 4'd3};
    vec[9]  = '{1'b1, 4'h7, 4'd3, 4'd3};
    vec[10] = '{1'b1, 4'h7, 4'd0, 4'd0};
    vec[11] = '{1'b1, 4'h6, 4'd0, 4'd1};
    vec[12] = '{1'b1, 4'h7, 4'd1, 4'd1};
    vec[13] = '{1'b1, 4'h6, 4'd0, 4'd2};
    vec[14] = '{1'b0, 4'hE, 4'd1, 4'd2};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_db", db_estado, 4'h0);
    chk("rst_end", endereco, 4'd0);
    chk("rst_rod", rodada, 4'd0);
    chk("rst_pronto", 4'(pronto), 4'd0);
    chk("rst_zeraR", 4'(zeraR), 4'd1);
    reset = 1'b1;
    tick();
    chk("idle_db", db_estado, 4'h0);

    start_game();
    for (int i = 0; i < 10; i++) play(vec[i]);
    wait_db(4'hA, "win_db");
    chk("win_acertou", 4'(acertou), 4'd1);
    chk("win_pronto", 4'(pronto), 4'd1);
    chk("win_errou", 4'(errou), 4'd0);
    chk("win_rod", rodada, 4'd3);

    start_game();
    for (int i = 10; i < 15; i++) play(vec[i]);
    chk("err_errou", 4'(errou), 4'd1);
    chk("err_pronto", 4'(pronto), 4'd1);
    chk("err_acertou", 4'(acertou), 4'd0);
    repeat (3) tick();
    chk("hold_db", db_estado, 4'hE);
    chk("hold_end", endereco, 4'd1);
    chk("hold_rod", rodada, 4'd2);

    start_game();
    iniciar = 1'b1;
    tick();
    chk("ign_iniciar", db_estado, 4'h3);
    iniciar = 1'b0;
    for (int i = 10; i < 13; i++) play(vec[i]);
    drive(vec[13]);
    #2 reset = 1'b0;
    #1;
    chk("mrst_db", db_estado, 4'h0);
    chk("mrst_end", endereco, 4'd0);
    chk("mrst_rod", rodada, 4'd0);
    chk("mrst_zeraR", 4'(zeraR), 4'd1);
    sb.delete();
    #3 reset = 1'b1;
    tick();
    chk("post_rst_db", db_estado, 4'h0);

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
    start_game();
    repeat (7) tick();
    chk("tmo_cycle8", db_estado, 4'h3);
    tick();
    chk("tmo_db", db_estado, 4'hD);
    chk("tmo_flag", 4'(timeout), 4'd1);
    chk("tmo_pronto", 4'(pronto), 4'd1);

    start_game();
    repeat (7) tick();
    tem_jogada = 1'b1;
    jogada     = 1'b1;
    tick();
    tem_jogada = 1'b0;
    chk("tmo_late_play", db_estado, 4'h4);
    chk("tmo_late_flag", 4'(timeout), 4'd0);
`else
    start_game();
    repeat (100) tick();
    chk("notmo_db", db_estado, 4'h3);
    chk("notmo_flag", 4'(timeout), 4'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
